// File: rtl/tx_link_if.sv
// Bundles the upstream byte stream, the encoder-facing character outputs and link status.
// The master modport is the upstream side; the slave modport is the link controller.
interface tx_link_if;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_ready;
    logic [7:0]  enc_data;
    logic        enc_k;
    logic        enc_enb;
    logic        link_up;
    logic        err_oversize;
    logic [15:0] frames_sent;

    modport master (
        output tx_valid, tx_data, tx_last,
        input  tx_ready, enc_data, enc_k, enc_enb, link_up, err_oversize, frames_sent
    );

    modport slave (
        input  tx_valid, tx_data, tx_last,
        output tx_ready, enc_data, enc_k, enc_enb, link_up, err_oversize, frames_sent
    );
endinterface

// File: rtl/tx_link_ctrl.sv
// Transmit link controller: comma alignment burst, K28.5 idle fill, SOF/EOF framing,
// inter-frame gap enforcement and oversize abort, feeding an 8b/10b encoder.
module tx_link_ctrl #(
    parameter int ALIGN_COUNT = 16,
    parameter int IFG         = 2,
    parameter int MAX_LEN     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       link_en,
    tx_link_if.slave   bus
);

    localparam logic [7:0] K_IDLE  = 8'hBC;
    localparam logic [7:0] K_SOF   = 8'hFB;
    localparam logic [7:0] K_EOF   = 8'hFD;
    localparam logic [7:0] K_ABORT = 8'hFE;

    typedef enum logic [2:0] {
        OFF, ALIGN, IDLE, DATA, EOF, ABORT, DROP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  enc_data_q, enc_data_d;
    logic        enc_k_q, enc_k_d;
    logic        enc_enb_q, enc_enb_d;
    logic        link_up_q, link_up_d;
    logic        err_oversize_q, err_oversize_d;
    logic [15:0] frames_sent_q, frames_sent_d;
    logic [7:0]  align_cnt_q, align_cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic [7:0]  len_q, len_d;

    logic        tx_ready;
    logic        accept;
    logic [7:0]  len_inc;

    assign tx_ready = (state_q == DATA) || (state_q == DROP);
    assign accept   = bus.tx_valid && tx_ready;
    assign len_inc  = len_q + 8'd1;

    always_comb begin
        state_d        = state_q;
        enc_data_d     = enc_data_q;
        enc_k_d        = enc_k_q;
        enc_enb_d      = enc_enb_q;
        link_up_d      = link_up_q;
        err_oversize_d = err_oversize_q;
        frames_sent_d  = frames_sent_q;
        align_cnt_d    = align_cnt_q;
        gap_d          = gap_q;
        len_d          = len_q;

        // Dropping link_en overrides the state machine and truncates any frame silently.
        if (!link_en) begin
            state_d    = OFF;
            enc_data_d = 8'h00;
            enc_k_d    = 1'b0;
            enc_enb_d  = 1'b0;
            link_up_d  = 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    enc_data_d  = 8'h00;
                    enc_k_d     = 1'b0;
                    enc_enb_d   = 1'b0;
                    link_up_d   = 1'b0;
                    align_cnt_d = 8'(ALIGN_COUNT);
                    state_d     = ALIGN;
                end
                ALIGN: begin
                    enc_data_d  = K_IDLE;
                    enc_k_d     = 1'b1;
                    enc_enb_d   = 1'b1;
                    align_cnt_d = align_cnt_q - 8'd1;
                    if (align_cnt_q == 8'd1) begin
                        link_up_d = 1'b1;
                        gap_d     = 4'd0;
                        state_d   = IDLE;
                    end
                end
                IDLE: begin
                    enc_k_d   = 1'b1;
                    enc_enb_d = 1'b1;
                    if (bus.tx_valid && gap_q == 4'd0) begin
                        enc_data_d = K_SOF;
                        len_d      = 8'd0;
                        state_d    = DATA;
                    end else begin
                        enc_data_d = K_IDLE;
                        if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
                    end
                end
                DATA: begin
                    enc_enb_d = 1'b1;
                    if (accept) begin
                        enc_data_d = bus.tx_data;
                        enc_k_d    = 1'b0;
                        len_d      = len_inc;
                        if (bus.tx_last)                    state_d = EOF;
                        else if (len_inc == 8'(MAX_LEN))    state_d = ABORT;
                    end else begin
                        enc_data_d = K_IDLE;
                        enc_k_d    = 1'b1;
                    end
                end
                EOF: begin
                    enc_data_d    = K_EOF;
                    enc_k_d       = 1'b1;
                    enc_enb_d     = 1'b1;
                    frames_sent_d = frames_sent_q + 16'd1;
                    gap_d         = 4'(IFG);
                    state_d       = IDLE;
                end
                ABORT: begin
                    enc_data_d     = K_ABORT;
                    enc_k_d        = 1'b1;
                    enc_enb_d      = 1'b1;
                    err_oversize_d = 1'b1;
                    state_d        = DROP;
                end
                DROP: begin
                    enc_data_d = K_IDLE;
                    enc_k_d    = 1'b1;
                    enc_enb_d  = 1'b1;
                    if (accept && bus.tx_last) begin
                        gap_d   = 4'(IFG);
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= OFF;
            enc_data_q     <= 8'h00;
            enc_k_q        <= 1'b0;
            enc_enb_q      <= 1'b0;
            link_up_q      <= 1'b0;
            err_oversize_q <= 1'b0;
            frames_sent_q  <= 16'd0;
            align_cnt_q    <= 8'd0;
            gap_q          <= 4'd0;
            len_q          <= 8'd0;
        end else begin
            state_q        <= state_d;
            enc_data_q     <= enc_data_d;
            enc_k_q        <= enc_k_d;
            enc_enb_q      <= enc_enb_d;
            link_up_q      <= link_up_d;
            err_oversize_q <= err_oversize_d;
            frames_sent_q  <= frames_sent_d;
            align_cnt_q    <= align_cnt_d;
            gap_q          <= gap_d;
            len_q          <= len_d;
        end
    end

    assign bus.tx_ready     = tx_ready;
    assign bus.enc_data     = enc_data_q;
    assign bus.enc_k        = enc_k_q;
    assign bus.enc_enb      = enc_enb_q;
    assign bus.link_up      = link_up_q;
    assign bus.err_oversize = err_oversize_q;
    assign bus.frames_sent  = frames_sent_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Directed bench for tx_link_ctrl with ALIGN_COUNT=4, IFG=2, MAX_LEN=4; every
// expected character below is hand-derived from the edge-by-edge behaviour.
module tb_tx_link_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic link_en;
    int   vectors    = 0;
    int   miscompares = 0;

    tx_link_if bus ();

    tx_link_ctrl #(
        .ALIGN_COUNT (4),
        .IFG         (2),
        .MAX_LEN     (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .link_en (link_en),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [7:0] data, input logic last);
        bus.tx_valid = valid;
        bus.tx_data  = data;
        bus.tx_last  = last;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compares {enb, k, data} against an enabled character with the given K flag.
    task automatic check_char(input string tag, input logic [7:0] data, input logic k);
        check_output(tag, {22'd0, bus.enc_enb, bus.enc_k, bus.enc_data}, {22'd0, 1'b1, k, data});
    endtask

    task automatic check_off(input string tag);
        check_output(tag, {27'd0, bus.enc_enb, bus.enc_k, |bus.enc_data, bus.tx_ready, bus.link_up}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        link_en = 1'b0;
        apply_stimulus(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check_off("reset_outputs");
        check_output("reset_err", {31'd0, bus.err_oversize}, 32'd0);
        check_output("reset_frames", {16'd0, bus.frames_sent}, 32'd0);

        // Bring-up: one edge OFF->ALIGN, then four commas with link_up on the fourth.
        reset   = 1'b0;
        link_en = 1'b1;
        tick();
        check_off("align_entry");
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_char($sformatf("align_comma%0d", i), 8'hBC, 1'b1);
            check_output($sformatf("align_linkup%0d", i), {31'd0, bus.link_up}, {31'd0, (i == 4)});
        end
        tick();
        check_char("idle_fill", 8'hBC, 1'b1);
        check_output("idle_ready", {31'd0, bus.tx_ready}, 32'd0);

        // Normal three-byte frame, second frame presented right after tx_last.
        apply_stimulus(1'b1, 8'h11, 1'b0);
        tick();
        check_char("f1_sof", 8'hFB, 1'b1);
        check_output("f1_ready", {31'd0, bus.tx_ready}, 32'd1);
        tick();
        check_char("f1_b1", 8'h11, 1'b0);
        apply_stimulus(1'b1, 8'h22, 1'b0);
        tick();
        check_char("f1_b2", 8'h22, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b1);
        tick();
        check_char("f1_b3", 8'h33, 1'b0);
        apply_stimulus(1'b1, 8'h44, 1'b0);
        tick();
        check_char("f1_eof", 8'hFD, 1'b1);
        check_output("f1_frames", {16'd0, bus.frames_sent}, 32'd1);
        tick();
        check_char("ifg_1", 8'hBC, 1'b1);
        tick();
        check_char("ifg_2", 8'hBC, 1'b1);
        tick();
        check_char("f2_sof", 8'hFB, 1'b1);

        // Second frame with a three-cycle valid gap mid-frame.
        tick();
        check_char("f2_b1", 8'h44, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_char($sformatf("f2_filler%0d", i), 8'hBC, 1'b1);
        end
        apply_stimulus(1'b1, 8'h55, 1'b1);
        tick();
        check_char("f2_b2", 8'h55, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        tick();
        check_char("f2_eof", 8'hFD, 1'b1);
        check_output("f2_frames", {16'd0, bus.frames_sent}, 32'd2);
        check_output("f2_no_err", {31'd0, bus.err_oversize}, 32'd0);
        tick();
        tick();

        // Oversize: six bytes against MAX_LEN=4.
        apply_stimulus(1'b1, 8'h01, 1'b0);
        tick();
        check_char("ov_sof", 8'hFB, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_char($sformatf("ov_b%0d", i), 8'(i), 1'b0);
            apply_stimulus(1'b1, 8'(i + 1), 1'b0);
        end
        tick();
        check_char("ov_abort", 8'hFE, 1'b1);
        check_output("ov_err", {31'd0, bus.err_oversize}, 32'd1);
        check_output("ov_drop_ready", {31'd0, bus.tx_ready}, 32'd1);
        tick();
        check_char("ov_drop5", 8'hBC, 1'b1);
        apply_stimulus(1'b1, 8'h06, 1'b1);
        tick();
        check_char("ov_drop6", 8'hBC, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("ov_frames", {16'd0, bus.frames_sent}, 32'd2);
        check_output("ov_idle_ready", {31'd0, bus.tx_ready}, 32'd0);
        tick();
        tick();

        // Frame after abort, then tx_last landing exactly on the MAX_LEN-th byte.
        apply_stimulus(1'b1, 8'hA1, 1'b1);
        tick();
        check_char("f3_sof", 8'hFB, 1'b1);
        tick();
        check_char("f3_b1", 8'hA1, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        tick();
        check_char("f3_eof", 8'hFD, 1'b1);
        check_output("f3_frames", {16'd0, bus.frames_sent}, 32'd3);
        tick();
        tick();
        apply_stimulus(1'b1, 8'hB1, 1'b0);
        tick();
        check_char("f4_sof", 8'hFB, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_char($sformatf("f4_b%0d", i), 8'hB0 + 8'(i), 1'b0);
            if (i < 3)       apply_stimulus(1'b1, 8'hB1 + 8'(i), 1'b0);
            else if (i == 3) apply_stimulus(1'b1, 8'hB4, 1'b1);
            else             apply_stimulus(1'b0, 8'h00, 1'b0);
        end
        tick();
        check_char("f4_eof", 8'hFD, 1'b1);
        check_output("f4_frames", {16'd0, bus.frames_sent}, 32'd4);
        check_output("f4_err_sticky", {31'd0, bus.err_oversize}, 32'd1);
        tick();
        tick();

        // Link disable after two payload bytes truncates the frame.
        apply_stimulus(1'b1, 8'hC1, 1'b0);
        tick();
        check_char("f5_sof", 8'hFB, 1'b1);
        tick();
        check_char("f5_b1", 8'hC1, 1'b0);
        apply_stimulus(1'b1, 8'hC2, 1'b0);
        tick();
        check_char("f5_b2", 8'hC2, 1'b0);
        apply_stimulus(1'b1, 8'hC3, 1'b0);
        link_en = 1'b0;
        tick();
        check_off("dis_outputs");
        check_output("dis_frames", {16'd0, bus.frames_sent}, 32'd4);
        tick();
        check_off("dis_hold");

        // Re-enable repeats the full alignment burst.
        apply_stimulus(1'b0, 8'h00, 1'b0);
        link_en = 1'b1;
        tick();
        check_off("re_align_entry");
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_char($sformatf("re_comma%0d", i), 8'hBC, 1'b1);
            check_output($sformatf("re_linkup%0d", i), {31'd0, bus.link_up}, {31'd0, (i == 4)});
        end

        // Reset mid-frame clears everything at the next edge with no EOF.
        apply_stimulus(1'b1, 8'hD1, 1'b0);
        tick();
        check_char("f6_sof", 8'hFB, 1'b1);
        tick();
        check_char("f6_b1", 8'hD1, 1'b0);
        reset = 1'b1;
        tick();
        check_off("midrst_outputs");
        check_output("midrst_frames", {16'd0, bus.frames_sent}, 32'd0);
        check_output("midrst_err", {31'd0, bus.err_oversize}, 32'd0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_link_ctrl.md
# tx_link_ctrl

Transmit-side link controller that drives the 8b/10b encoder block's byte, control and enable inputs. It brings the link up with an alignment burst of commas, fills idle time with K28.5, and frames each packet from an upstream valid/ready byte stream between K27.7 (SOF) and K29.7 (EOF). It also enforces a minimum inter-frame gap and aborts oversize frames with K30.7. It sits directly in front of the encoder, and its three encoder-facing outputs connect one-to-one to the encoder's data, K and enable inputs.

## Interface
- ALIGN_COUNT, 16: consecutive K28.5 characters emitted after link enable before link_up; legal range 1..255.
- IFG, 2: minimum idle characters between EOF/abort and the next SOF; legal range 0..15.
- MAX_LEN, 64: maximum payload bytes per frame; legal range 1..255.

- clk  in  1  rising-edge clock for all logic
- reset  in  1  synchronous, active-high reset
- link_en  in  1  enables link; low forces OFF
- tx_valid  in  1  upstream byte valid
- tx_data  in  8  upstream payload byte
- tx_last  in  1  marks final byte of frame, qualified by tx_valid
- tx_ready  out  1  controller accepts tx_data this cycle
- enc_data  out  8  byte to encoder data input
- enc_k  out  1  control-character flag to encoder K input
- enc_enb  out  1  encoder enable
- link_up  out  1  alignment complete, framing permitted
- err_oversize  out  1  sticky; set on any MAX_LEN abort, cleared only by reset
- frames_sent  out  16  count of frames closed with EOF, wraps at 0xFFFF -> 0

## Operation
- Character codes (enc_k=1): K28.5=0xBC (comma/idle), K27.7=0xFB (SOF), K29.7=0xFD (EOF), K30.7=0xFE (abort). Payload bytes use enc_k=0.
- All outputs are registered. tx_ready is decoded from the state register only (1 in DATA and DROP, else 0). A byte is accepted when tx_valid && tx_ready.
- States are OFF, ALIGN, IDLE, DATA, EOF, ABORT and DROP. At each edge the output register is loaded according to the current state and inputs:
  - OFF: load enc_enb=0, enc_data=0, enc_k=0, link_up=0. If link_en=1, load align counter with ALIGN_COUNT and go to ALIGN.
  - ALIGN: load 0xBC with K=1 and enb=1, then decrement the counter. When the counter reaches 1, set link_up=1, clear the gap counter and go to IDLE.
  - IDLE: if tx_valid=1 and gap=0, load 0xFB, clear the length counter and go to DATA. Otherwise load 0xBC and decrement gap if it is nonzero.
  - DATA: on accept, load tx_data with K=0 and increment length.
    - If tx_last=1, go to EOF.
    - Else if the new length equals MAX_LEN, go to ABORT.
    - With no accept, load K28.5 filler and stay in DATA.
  - EOF: load 0xFD, increment frames_sent, set gap=IFG and go to IDLE.
  - ABORT: load 0xFE, set err_oversize=1 and go to DROP.
  - DROP: load 0xBC and discard accepted bytes. An accept with tx_last=1 sets gap=IFG and goes to IDLE.
- Priority is reset > link_en=0 > state logic. link_en=0 in any state other than OFF moves to OFF at the next edge and loads OFF outputs. An in-progress frame is truncated with no EOF or abort character, and frames_sent is unchanged.
- A tx_last byte accepted as the MAX_LEN-th byte closes the frame normally through EOF, not ABORT.
- The length counter is 8 bits and never exceeds MAX_LEN.

## Timing
- Reset values: enc_data=0x00, enc_k=0, enc_enb=0, tx_ready=0, link_up=0, err_oversize=0, frames_sent=0, state OFF, all counters 0.
- Latency from link_en rising to the first 0xBC on enc_data is 2 edges: OFF→ALIGN, then the ALIGN load.
- link_up rises on the same edge that loads the ALIGN_COUNT-th comma.
- SOF appears 1 edge after tx_valid is sampled in IDLE with gap=0. tx_ready rises on that same edge.
- An accepted byte appears on enc_data at the next edge. EOF appears one edge after the last byte.
- Minimum distance from the EOF character to the next SOF is IFG+1 edges.
- Reset asserted mid-frame takes effect at the next edge and emits no EOF.

## Test plan
- Bring-up: reset, then link_en=1 with ALIGN_COUNT=4.
  - Required: enc_data shows 0xBC×4 with K=1.
  - link_up rises with the 4th comma.
  - Output continues as 0xBC idles.
- Normal frame: tx_valid held with bytes 0x11, 0x22, 0x33 and tx_last on 0x33.
  - Required: enc_data sequence 0xFB(K), 0x11, 0x22, 0x33 (K=0), 0xFD(K).
  - frames_sent becomes 1.
- Back-to-back frames with IFG=2: the second frame is valid immediately after the first's tx_last.
  - Required: exactly 2 × 0xBC between 0xFD and the next 0xFB.
- Valid gaps: tx_valid drops for 3 cycles mid-frame.
  - Required: three 0xBC fillers are inserted, the payload is intact, and there is no abort.
- Oversize, MAX_LEN=4: a 6-byte frame is sent.
  - Required: 4 payload bytes, then 0xFE(K).
  - err_oversize=1; bytes 5 and 6 are consumed with 0xBC output.
  - frames_sent is unchanged; the next frame frames normally.
- Abort on disable: link_en=0 after 2 payload bytes.
  - Required: next edge enc_enb=0, enc_data=0, tx_ready=0, link_up=0.
  - Re-enable repeats the full alignment burst.
